led_counter: RTL and testbench



---
 rtl/led_counter.sv | 92 +++++++++
 tb/tb_led_counter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_counter.sv
// Ten-bit LED counter for the DE-series board: prescaled run mode plus load,
// clear and single-step pushbuttons, shown directly on the red LEDs.
module led_counter #(
  parameter int PRESCALE = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic          rst_n;
  logic          run;
  logic          down;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    prev;
  logic [2:0]    valid;
  logic [2:0]    press;
  logic          load_ev;
  logic          clear_ev;
  logic          step_ev;
  logic          tick;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_next;
  logic [9:0]    count;
  logic [9:0]    count_next;

  assign rst_n = KEY[0];
  assign run   = SW[9];
  assign down  = SW[8];

  // valid walks in a 1 so edges are only accepted between two genuine samples,
  // which keeps a button held through reset release from looking like a press.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      valid <= '0;
    end else begin
      sync1 <= KEY[3:1];
      sync2 <= sync1;
      prev  <= sync2;
      valid <= {valid[1:0], 1'b1};
    end
  end

  assign press    = {3{valid[2]}} & prev & ~sync2;
  assign load_ev  = press[0];
  assign clear_ev = press[1];
  assign step_ev  = press[2];

  assign tick = run && (prescaler == PS_LAST);

  always_comb begin
    count_next     = count;
    prescaler_next = prescaler;
    if (clear_ev) begin
      count_next     = '0;
      prescaler_next = '0;
    end else if (load_ev) begin
      count_next     = {2'b00, SW[7:0]};
      prescaler_next = '0;
    end else begin
      if (!run || tick) begin
        prescaler_next = '0;
      end else begin
        prescaler_next = prescaler + PW'(1);
      end
      if (tick || (step_ev && !run)) begin
        count_next = down ? (count - 10'd1) : (count + 10'd1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      prescaler <= '0;
    end else begin
      count     <= count_next;
      prescaler <= prescaler_next;
    end
  end

  assign LEDR = count;

endmodule

// File: tb/tb_led_counter.sv
// Randomized and directed bench for led_counter against a cycle-level model
// built from the button-delay, priority and tick-period rules.
module tb_led_counter;

  localparam int PRESCALE = 4;

  logic       CLOCK_50;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  int tests_run;
  int tests_failed;

  // Model state: last four sampled button values, tick phase and count.
  logic [2:0] hist[$];
  logic [2:0] m_ev;
  int         m_phase;
  int         m_dir;
  logic [9:0] m_count;

  led_counter #(.PRESCALE(PRESCALE)) dut (
    .CLOCK_50(CLOCK_50),
    .KEY     (KEY),
    .SW      (SW),
    .LEDR    (LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // A press takes effect on the edge two after the first low sample, and only
  // when the sample before that was a genuine post-reset high.
  always @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      m_count = '0;
      m_phase = 0;
      hist.delete();
    end else begin
      hist.push_front(KEY[3:1]);
      if (hist.size() > 4) void'(hist.pop_back());
      m_ev = '0;
      if (hist.size() == 4) m_ev = hist[3] & ~hist[2];
      m_dir = SW[8] ? 1023 : 1;
      if (m_ev[1]) begin
        m_count = '0;
        m_phase = 0;
      end else if (m_ev[0]) begin
        m_count = {2'b00, SW[7:0]};
        m_phase = 0;
      end else if (SW[9]) begin
        m_phase = m_phase + 1;
        if (m_phase == PRESCALE) begin
          m_phase = 0;
          m_count = 10'((int'(m_count) + m_dir) % 1024);
        end
      end else begin
        m_phase = 0;
        if (m_ev[2]) m_count = 10'((int'(m_count) + m_dir) % 1024);
      end
    end
  end

  task automatic test_reset();
    KEY = 4'b0000;
    SW  = 10'h200;
    repeat (3) @(negedge CLOCK_50);
    tests_run++;
    if (LEDR !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_value: LEDR=%0d expected 0", LEDR);
    end
    KEY = 4'b1111;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLOCK_50);
      tests_run++;
      if (LEDR !== 10'(i / PRESCALE)) begin
        tests_failed++;
        $display("[TB] FAIL run_cadence cycle %0d: LEDR=%0d expected %0d", i, LEDR, i / PRESCALE);
      end
      tests_run++;
      if (LEDR !== m_count) begin
        tests_failed++;
        $display("[TB] FAIL run_model cycle %0d: LEDR=%0d expected %0d", i, LEDR, m_count);
      end
    end
  endtask

  task automatic test_wrap();
    int  guard;
    logic [9:0] exp;
    SW  = 10'h2FF;
    KEY = 4'b1101;
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1111;
    guard = 0;
    while (m_count !== 10'd1023 && guard < 4000) begin
      @(negedge CLOCK_50);
      guard++;
      tests_run++;
      if (LEDR !== m_count) begin
        tests_failed++;
        $display("[TB] FAIL wrap_model: LEDR=%0d expected %0d", LEDR, m_count);
      end
    end
    tests_run++;
    if (guard >= 4000) begin
      tests_failed++;
      $display("[TB] FAIL wrap_timeout: LEDR=%0d never reached 1023", LEDR);
    end
    repeat (PRESCALE) @(negedge CLOCK_50);
    exp = 10'd0;
    tests_run++;
    if (LEDR !== exp) begin
      tests_failed++;
      $display("[TB] FAIL wrap_up: LEDR=%0d expected %0d", LEDR, exp);
    end
    SW[8] = 1'b1;
    repeat (PRESCALE) @(negedge CLOCK_50);
    exp = 10'd1023;
    tests_run++;
    if (LEDR !== exp) begin
      tests_failed++;
      $display("[TB] FAIL wrap_down: LEDR=%0d expected %0d", LEDR, exp);
    end
  endtask

  task automatic test_load_clear();
    SW  = 10'h0A5;
    KEY = 4'b1101;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLOCK_50);
      tests_run++;
      if (LEDR !== m_count) begin
        tests_failed++;
        $display("[TB] FAIL load_model cycle %0d: LEDR=%0d expected %0d", i, LEDR, m_count);
      end
    end
    tests_run++;
    if (LEDR !== 10'd165) begin
      tests_failed++;
      $display("[TB] FAIL load_value: LEDR=%0d expected 165", LEDR);
    end
    KEY = 4'b1111;
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1011;
    repeat (3) @(negedge CLOCK_50);
    tests_run++;
    if (LEDR !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_value: LEDR=%0d expected 0", LEDR);
    end
    KEY = 4'b1111;
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1101;
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1111;
    repeat (3) @(negedge CLOCK_50);
    tests_run++;
    if (LEDR !== 10'd165) begin
      tests_failed++;
      $display("[TB] FAIL reload_value: LEDR=%0d expected 165", LEDR);
    end
    KEY = 4'b1001;
    repeat (3) @(negedge CLOCK_50);
    tests_run++;
    if (LEDR !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_beats_load: LEDR=%0d expected 0", LEDR);
    end
    KEY = 4'b1111;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic test_step();
    logic [9:0] base;
    SW   = 10'h000;
    base = m_count;
    KEY  = 4'b0111;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLOCK_50);
      tests_run++;
      if (LEDR !== m_count) begin
        tests_failed++;
        $display("[TB] FAIL step_model cycle %0d: LEDR=%0d expected %0d", i, LEDR, m_count);
      end
    end
    tests_run++;
    if (LEDR !== base + 10'd1) begin
      tests_failed++;
      $display("[TB] FAIL step_once: LEDR=%0d expected %0d", LEDR, base + 10'd1);
    end
    KEY = 4'b1111;
    repeat (3) @(negedge CLOCK_50);
    SW  = 10'h200;
    KEY = 4'b0111;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLOCK_50);
      tests_run++;
      if (LEDR !== m_count) begin
        tests_failed++;
        $display("[TB] FAIL step_while_run cycle %0d: LEDR=%0d expected %0d", i, LEDR, m_count);
      end
    end
    KEY = 4'b1111;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic test_pause();
    logic [9:0] saved;
    SW = 10'h200;
    repeat (10) @(negedge CLOCK_50);
    SW    = 10'h000;
    saved = m_count;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLOCK_50);
      tests_run++;
      if (LEDR !== saved) begin
        tests_failed++;
        $display("[TB] FAIL pause_hold cycle %0d: LEDR=%0d expected %0d", i, LEDR, saved);
      end
    end
    SW = 10'h200;
    for (int i = 1; i <= PRESCALE; i++) begin
      @(negedge CLOCK_50);
      tests_run++;
      if (LEDR !== ((i == PRESCALE) ? saved + 10'd1 : saved)) begin
        tests_failed++;
        $display("[TB] FAIL resume cycle %0d: LEDR=%0d expected %0d", i, LEDR,
                 (i == PRESCALE) ? saved + 10'd1 : saved);
      end
    end
  endtask

  task automatic test_async_reset();
    SW  = 10'h025;
    KEY = 4'b1101;
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1111;
    repeat (3) @(negedge CLOCK_50);
    tests_run++;
    if (LEDR !== 10'd37) begin
      tests_failed++;
      $display("[TB] FAIL preset_37: LEDR=%0d expected 37", LEDR);
    end
    @(posedge CLOCK_50);
    #2 KEY = 4'b0000;
    #1;
    tests_run++;
    if (LEDR !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_clear: LEDR=%0d expected 0", LEDR);
    end
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b0001;
    for (int i = 1; i <= 18; i++) begin
      @(negedge CLOCK_50);
      if (i == 12) KEY = 4'b1111;
      tests_run++;
      if (LEDR !== 10'd0) begin
        tests_failed++;
        $display("[TB] FAIL held_key_no_event cycle %0d: LEDR=%0d expected 0", i, LEDR);
      end
    end
    KEY = 4'b1101;
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1111;
    tests_run++;
    if (LEDR !== 10'd37) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_load: LEDR=%0d expected 37", LEDR);
    end
  endtask

  task automatic test_random();
    int b;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLOCK_50);
      tests_run++;
      if (LEDR !== m_count) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: LEDR=%0d expected %0d", i, LEDR, m_count);
      end
      if ($urandom_range(0, 7) == 0) begin
        b = int'($urandom_range(3, 1));
        KEY[b] = ~KEY[b];
      end
      if ($urandom_range(0, 39) == 0) SW = 10'($urandom);
    end
    KEY = 4'b1111;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    KEY = 4'b0000;
    SW  = 10'h000;
    test_reset();
    test_wrap();
    test_load_clear();
    test_step();
    test_pause();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
